// File: rtl/keypad_scan_if.sv
// keypad_scan_if: key report channel between the keypad scanner and the
// clock-setting logic. Build option for the scanner: KEYPAD_AUTOREPEAT_EN.
//
// Handshake: the master raises key_valid with key_code when a report is
// made. The slave accepts it by holding key_ack high on a rising clk edge
// while key_valid is high; key_valid drops on that edge. key_ack while
// key_valid is low is ignored. A new report on the same edge as an ack
// wins: key_valid stays high with the new code.
interface keypad_scan_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ack;
   logic       key_held;
   logic       overrun;
   logic [1:0] dbg_state;

   modport master (
      output key_code, key_valid, key_held, overrun, dbg_state,
      input  key_ack
   );

   modport slave (
      input  key_code, key_valid, key_held, overrun, dbg_state,
      output key_ack
   );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad scanner with frame debounce and one key
// report per press over a valid/ack channel.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (re-report a held key every
// REPEAT_FRAMES frames). Without it exactly one report is made per press.
module keypad_scan #(
   parameter int SCAN_DIV      = 10000,
   parameter int DIV_WIDTH     = 17,
   parameter int DEBOUNCE      = 4,
   parameter int REPEAT_FRAMES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  ROW,
   output logic [3:0]  COL,
   keypad_scan_if.master kp
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DEB     = 2'd1,
      S_PRESSED = 2'd2,
      S_REL     = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]     DEB_L    = CNT_W'(DEBOUNCE);

   logic [DIV_WIDTH-1:0] r_div;
   logic [1:0]           r_col_idx;
   logic [15:0]          r_frame;
   state_t               r_state;
   logic [3:0]           r_cand;
   logic [CNT_W-1:0]     r_cnt;
   logic [3:0]           r_key_code;
   logic                 r_key_valid;
   logic                 r_overrun;

   logic                 w_tick;
   logic                 w_frame_done;
   logic [15:0]          w_frame_nxt;
   logic [4:0]           w_ones;
   logic [3:0]           w_key;
   logic                 w_none;
   logic                 w_single;
   state_t               w_state_nxt;
   logic [3:0]           w_cand_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [CNT_W-1:0]     w_cnt_inc;
   logic                 w_report;
   logic [3:0]           w_rep_code;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
   localparam logic [REP_W-1:0] REP_L = REP_W'(REPEAT_FRAMES);
   logic [REP_W-1:0]     r_rep_cnt;
   logic [REP_W-1:0]     w_rep_nxt;
   logic [REP_W-1:0]     w_rep_inc;
   assign w_rep_inc = r_rep_cnt + 1'b1;
`endif

   assign w_tick       = (r_div == DIV_LAST);
   assign w_frame_done = w_tick && (r_col_idx == 2'd3);
   assign w_cnt_inc    = r_cnt + 1'b1;
   assign w_none       = (w_ones == 5'd0);
   assign w_single     = (w_ones == 5'd1);

   // Column drive is decoded from the registered column index only.
   assign COL = ~(4'b0001 << r_col_idx);

   assign kp.key_code  = r_key_code;
   assign kp.key_valid = r_key_valid;
   assign kp.overrun   = r_overrun;
   assign kp.key_held  = (r_state == S_PRESSED) || (r_state == S_REL);
   assign kp.dbg_state = r_state;

   // Slot counter, column rotation and frame capture at each slot end.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div     <= '0;
         r_col_idx <= 2'd0;
         r_frame   <= '0;
      end else if (w_tick) begin
         r_div     <= '0;
         r_col_idx <= r_col_idx + 2'd1;
         r_frame   <= w_frame_nxt;
      end else begin
         r_div     <= r_div + 1'b1;
      end
   end

   // Frame as it will look after this slot's sample: the current column's
   // four row bits replaced by the inverted rows (bit index 4*row + col).
   always_comb begin
      w_frame_nxt = r_frame;
      for (int r = 0; r < 4; r++) begin
         w_frame_nxt[{2'(r), r_col_idx}] = ~ROW[r];
      end
   end

   // Count pressed keys in the frame and remember the position of a set bit.
   always_comb begin
      w_ones = '0;
      w_key  = '0;
      for (int i = 0; i < 16; i++) begin
         if (w_frame_nxt[i]) begin
            w_ones = w_ones + 5'd1;
            w_key  = 4'(i);
         end
      end
   end

   // Debounce FSM state registers; they only move on frame completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cand  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cand  <= w_cand_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   // Frames spent in PRESSED since entry or since the last repeat report.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rep_cnt <= '0;
      else      r_rep_cnt <= w_rep_nxt;
   end
`endif

   // Debounce FSM next state and report request; MULTI counts as NONE for
   // press detection and as still-pressed while releasing.
   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_cnt_nxt   = r_cnt;
      w_report    = 1'b0;
      w_rep_code  = r_cand;
`ifdef KEYPAD_AUTOREPEAT_EN
      w_rep_nxt   = r_rep_cnt;
`endif
      if (w_frame_done) begin
         case (r_state)
            S_IDLE: begin
               if (w_single) begin
                  w_cand_nxt = w_key;
                  w_cnt_nxt  = CNT_W'(1);
                  if (DEBOUNCE == 1) begin
                     w_state_nxt = S_PRESSED;
                     w_report    = 1'b1;
                     w_rep_code  = w_key;
                  end else begin
                     w_state_nxt = S_DEB;
                  end
               end
            end
            S_DEB: begin
               if (w_single && (w_key == r_cand)) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == DEB_L) begin
                     w_state_nxt = S_PRESSED;
                     w_report    = 1'b1;
                  end
               end else if (w_single) begin
                  w_cand_nxt = w_key;
                  w_cnt_nxt  = CNT_W'(1);
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_PRESSED: begin
               if (w_none) begin
                  w_cnt_nxt   = CNT_W'(1);
                  w_state_nxt = (DEBOUNCE == 1) ? S_IDLE : S_REL;
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               else if (w_rep_inc == REP_L) begin
                  w_report  = 1'b1;
                  w_rep_nxt = '0;
               end else begin
                  w_rep_nxt = w_rep_inc;
               end
`endif
            end
            S_REL: begin
               if (w_none) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == DEB_L) w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_PRESSED;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
`ifdef KEYPAD_AUTOREPEAT_EN
         if (w_state_nxt != S_PRESSED) w_rep_nxt = '0;
`endif
      end
   end

   // Report channel: a report beats a simultaneous ack; overrun is sticky.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else if (w_report) begin
         r_key_code  <= w_rep_code;
         r_key_valid <= 1'b1;
         if (r_key_valid && !kp.key_ack) r_overrun <= 1'b1;
      end else if (kp.key_ack && r_key_valid) begin
         r_key_valid <= 1'b0;
      end
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanned 4x4 hex keypad reader, the input-side counterpart of the multiplexed seven-segment display driver. It drives one active-low column at a time and samples the four active-low rows at the end of each column slot. Each complete 4-column frame is debounced, and one key code per press is delivered to the clock-setting logic over a valid/ack handshake. It shares the system clock and reset with the display path and uses the same slot-timing style as the display's digit scan.

## Interface
- SCAN_DIV, 10000: clocks per column slot; must be ≥2.
- DIV_WIDTH, 17: width of the slot counter; 2^DIV_WIDTH must be ≥ SCAN_DIV.
- DEBOUNCE, 4: consecutive identical frames required to accept a press or a release; must be ≥1.
- REPEAT_FRAMES, 32: auto-repeat period in frames; used only with KEYPAD_AUTOREPEAT_EN.
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- ROW  input  4  keypad rows, active-low, pulled up externally.
- key_ack  input  1  consumer acknowledge; sampled on the rising edge of clk.
- COL  output  4  column drive, one-hot active-low (0 = driven).
- key_code  output  4  latched key, code = 4*row + col.
- key_valid  output  1  a new key_code is pending.
- key_held  output  1  a key is currently accepted as pressed.
- overrun  output  1  sticky flag: a report overwrote an unacknowledged one.

## Operation
- Slot counter counts 0..SCAN_DIV-1 and wraps. The tick is the cycle where the count equals SCAN_DIV-1.
- On tick: ROW is inverted and stored into frame bits [4*r+c] for the current column c. COL then rotates 1110→1101→1011→0111→1110. Sampling happens at the slot end, so rows have settled.
- Frame complete: the tick of column 3. Frame classification:
  - NONE: 0 bits set.
  - SINGLE(k): exactly 1 bit set, at position k.
  - MULTI: 2 or more bits set. MULTI is treated as NONE for press detection and as "not released" in PRESSED.
- FSM, evaluated only at frame complete:
  - IDLE: SINGLE(k) → DEB with cand=k, cnt=1. With DEBOUNCE=1, go directly to PRESSED and report.
  - DEB: SINGLE(cand) → cnt+1; when cnt reaches DEBOUNCE → PRESSED and report. SINGLE(j≠cand) → restart with cand=j, cnt=1. NONE/MULTI → IDLE.
  - PRESSED: NONE → REL with cnt=1. With DEBOUNCE=1, go directly to IDLE. Anything else → stay.
  - REL: NONE → cnt+1; when cnt reaches DEBOUNCE → IDLE. Anything else → PRESSED.
- Report: key_code←cand and key_valid←1.
  - If key_valid is already 1 and key_ack is 0 in the same cycle, overrun←1.
- key_ack=1 while key_valid=1: key_valid←0 on that edge. key_ack while key_valid=0 is ignored.
- Report and key_ack in the same cycle: the report wins. key_valid stays 1, key_code is updated, overrun is not set.
- key_held = 1 in PRESSED and REL, 0 otherwise.
- overrun clears only on reset.
- Reset values: COL=1110, key_code=0, key_valid=0, key_held=0, overrun=0, slot counter=0, frame=0, state=IDLE.
- Reset asserted mid-operation aborts everything immediately and asynchronously. After release, scanning restarts at column 0 with a fresh frame; no partial frame survives.

## Timing
- Frame length is 4*SCAN_DIV clocks. Column 0 is driven for SCAN_DIV clocks after reset release.
- key_valid, key_code, key_held and overrun update on the clock edge that ends the frame-complete tick cycle. They are visible in the following cycle.
- Press latency: a key stable from the start of frame f is reported at the end of frame f+DEBOUNCE-1.
- Release latency: the same figure, counted from the first all-NONE frame.
- key_valid falls one edge after key_ack is sampled high. There is no combinational ROW→output path.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - While in PRESSED, a frame counter runs from entry into the state.
  - Every REPEAT_FRAMES complete frames, the same key is reported again, with the same overrun and ack rules as a normal report.
  - The counter clears on leaving PRESSED and does not run in REL.
- Not defined: exactly one report per press; REPEAT_FRAMES is unused and no repeat counter is synthesized.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3, REPEAT_FRAMES=2, ROW=1111 unless stated.
- Reset: hold rst=0 → all outputs at reset values, COL=1110. Release → COL steps 1101, 1011, 0111, 1110 at 4-clock intervals.
- Clean press: ROW=1101 whenever COL=1011 (key 6) from frame 0 → after the 3rd frame, key_code=6, key_valid=1, key_held=1. Pulse key_ack → key_valid=0 next cycle. Release → key_held=0 after 3 NONE frames.
- Bounce: key 6 alternates present/absent per frame for 10 frames → key_valid remains 0.
- Multi-key: keys 0 and 5 held → no report. Release key 0 → key 5 reported 3 frames later.
- Overrun and collision: press key 1 with no ack, release, press key 2 → key_code=2, overrun=1. Repeat with key_ack high on the report cycle → overrun unchanged.
- Reset mid-DEB and auto-repeat: assert rst after 2 frames of key 3 → reset values; after release, key 3 needs 3 full frames. With KEYPAD_AUTOREPEAT_EN defined, holding key 3 re-asserts key_valid every 2 frames.
